inst_bram_resp: RTL and testbench

INST_BRAM_RESP -- requirements
Module: inst_bram_resp

---
 rtl/inst_bram_resp_pkg.sv | 22 ++
 rtl/inst_bram_resp_bram.sv | 40 ++++
 rtl/inst_bram_resp.sv | 128 ++++++++++++
 tb/tb_inst_bram_resp.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/inst_bram_resp_pkg.sv
// ---------------------------------------------------------------
// inst_bram_resp_pkg : shared widths, constants and state codes
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package inst_bram_resp_pkg;

    localparam int          DEPTH_LOG2_DEFAULT = 10;
    localparam int          INST_ADDR_W        = 32;
    localparam int          INST_W             = 32;
    localparam logic [31:0] ZERO_WORD          = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_READ = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/inst_bram_resp_bram.sv
// ---------------------------------------------------------------
// inst_bram : instruction store, one sync write port, one registered read port
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module inst_bram
    import inst_bram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [INST_W-1:0]     i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [INST_W-1:0]     o_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [INST_W-1:0] r_mem [0:DEPTH-1];
    logic [INST_W-1:0] r_rdata;

    // Contents and read register are deliberately left unreset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/inst_bram_resp.sv
// ---------------------------------------------------------------
// inst_bram_resp : boot loader port plus fetch responder with a one-word output buffer
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module inst_bram_resp
    import inst_bram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce,
    input  logic [INST_ADDR_W-1:0] rom_addr,
    output logic [INST_W-1:0]      rom_data,
    output logic                   stall_req,
    output logic                   addr_err,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [DEPTH_LOG2-1:0]  ld_addr,
    input  logic [INST_W-1:0]      ld_data,
    input  logic                   ld_done
);

    state_t                  r_state;
    logic [INST_W-1:0]       r_buf;
    logic [DEPTH_LOG2-1:0]   r_tag;
    logic                    r_valid;
    logic [DEPTH_LOG2-1:0]   r_pend_idx;

    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_err;
    logic                    w_hit;
    logic                    w_ram_we;
    logic                    w_ram_re;
    logic [INST_W-1:0]       w_ram_rdata;

    assign w_idx    = rom_addr[DEPTH_LOG2+1:2];
    assign w_err    = (|rom_addr[INST_ADDR_W-1:DEPTH_LOG2+2]) | (|rom_addr[1:0]);
    assign w_hit    = r_valid && (r_tag == w_idx);
    assign w_ram_we = (r_state == ST_BOOT) && ld_valid;

    inst_bram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_inst_bram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (ld_addr),
        .i_wdata (ld_data),
        .i_re    (w_ram_re),
        .i_raddr (w_idx),
        .o_rdata (w_ram_rdata)
    );

    // Hit and READ data bypass straight to rom_data so a hit costs no cycle and a miss costs one.
    always_comb begin
        rom_data  = ZERO_WORD;
        stall_req = 1'b0;
        addr_err  = 1'b0;
        ld_ready  = 1'b0;
        w_ram_re  = 1'b0;
        case (r_state)
            ST_BOOT: begin
                stall_req = 1'b1;
                ld_ready  = 1'b1;
            end
            ST_IDLE: begin
                if (rom_ce) begin
                    if (w_err) begin
                        addr_err = 1'b1;
                    end else if (w_hit) begin
                        rom_data = r_buf;
                    end else begin
                        stall_req = 1'b1;
                        w_ram_re  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (rom_ce) begin
                    rom_data = w_ram_rdata;
                end
            end
            default: begin
                stall_req = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_BOOT;
            r_buf      <= ZERO_WORD;
            r_tag      <= '0;
            r_valid    <= 1'b0;
            r_pend_idx <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (ld_done) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (rom_ce && !w_err && !w_hit) begin
                        r_pend_idx <= w_idx;
                        r_state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Tag comes from the index captured at issue, not the live address.
                    r_buf   <= w_ram_rdata;
                    r_tag   <= r_pend_idx;
                    r_valid <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_bram_resp.sv
// ---------------------------------------------------------------
// tb_inst_bram_resp : directed self-checking bench for inst_bram_resp
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_inst_bram_resp;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        stall_req;
    logic        addr_err;
    logic        ld_valid;
    logic        ld_ready;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] W0 = 32'h3401_1100;
    localparam logic [31:0] W1 = 32'h3402_0020;

    inst_bram_resp #(.DEPTH_LOG2(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_ce    (rom_ce),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .stall_req (stall_req),
        .addr_err  (addr_err),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_done   (ld_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply a fetch request at the falling edge and let combinational outputs settle.
    task automatic fetch(input logic ce, input logic [31:0] addr);
        @(negedge clk);
        rom_ce   = ce;
        rom_addr = addr;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; rom_ce = 1'b0; rom_addr = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
        @(negedge clk); #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", stall_req); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
        checks++; if (rom_data !== 32'h0) begin errors++; $display("FAIL reset_rom_data: got %h want 00000000", rom_data); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_load;
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 10'd0; ld_data = W0;
        #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL boot_ld_ready: got %b want 1", ld_ready); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL boot_stall: got %b want 1", stall_req); end
        @(negedge clk);
        ld_addr = 10'd1; ld_data = W1; ld_done = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; ld_done = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL idle_ld_ready: got %b want 0", ld_ready); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b want 0", stall_req); end
        checks++; if (rom_data !== 32'h0) begin errors++; $display("FAIL idle_rom_data: got %h want 00000000", rom_data); end
    endtask

    task automatic test_miss_then_hit;
        fetch(1'b1, 32'h0);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL miss0_stall: got %b want 1", stall_req); end
        fetch(1'b1, 32'h0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL read0_stall: got %b want 0", stall_req); end
        checks++; if (rom_data !== W0) begin errors++; $display("FAIL read0_data: got %h want %h", rom_data, W0); end
        fetch(1'b1, 32'h0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL hit0_stall: got %b want 0", stall_req); end
        checks++; if (rom_data !== W0) begin errors++; $display("FAIL hit0_data: got %h want %h", rom_data, W0); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [4];
        logic [31:0] words [4];
        addrs = '{32'h4, 32'h0, 32'h4, 32'h0};
        words = '{W1, W0, W1, W0};
        for (int i = 0; i < 4; i++) begin
            fetch(1'b1, addrs[i]);
            checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL b2b_stall[%0d]: got %b want 1", i, stall_req); end
            fetch(1'b1, addrs[i]);
            checks++; if (stall_req !== 1'b0 || rom_data !== words[i]) begin
                errors++; $display("FAIL b2b_serve[%0d]: got stall=%b data=%h want stall=0 data=%h", i, stall_req, rom_data, words[i]);
            end
        end
    endtask

    task automatic test_addr_err;
        fetch(1'b1, 32'h2);
        checks++; if (addr_err !== 1'b1 || stall_req !== 1'b0 || rom_data !== 32'h0) begin
            errors++; $display("FAIL misalign: got err=%b stall=%b data=%h want err=1 stall=0 data=0", addr_err, stall_req, rom_data);
        end
        fetch(1'b1, 32'h1000);
        checks++; if (addr_err !== 1'b1 || stall_req !== 1'b0 || rom_data !== 32'h0) begin
            errors++; $display("FAIL range: got err=%b stall=%b data=%h want err=1 stall=0 data=0", addr_err, stall_req, rom_data);
        end
        fetch(1'b1, 32'h0);
        checks++; if (addr_err !== 1'b0 || stall_req !== 1'b0 || rom_data !== W0) begin
            errors++; $display("FAIL after_err_hit: got err=%b stall=%b data=%h want err=0 stall=0 data=%h", addr_err, stall_req, rom_data, W0);
        end
    endtask

    task automatic test_ld_ignored;
        @(negedge clk);
        rom_ce = 1'b0; ld_valid = 1'b1; ld_addr = 10'd0; ld_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL idle_ld_ignored_ready: got %b want 0", ld_ready); end
        @(negedge clk);
        ld_valid = 1'b0;
        fetch(1'b1, 32'h4);
        fetch(1'b1, 32'h4);
        fetch(1'b1, 32'h0);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL ld_ign_miss: got %b want 1", stall_req); end
        fetch(1'b1, 32'h0);
        checks++; if (rom_data !== W0) begin errors++; $display("FAIL ld_ign_data: got %h want %h", rom_data, W0); end
    endtask

    task automatic test_ce_drop;
        fetch(1'b1, 32'h4);
        fetch(1'b0, 32'h4);
        checks++; if (rom_data !== 32'h0 || stall_req !== 1'b0) begin
            errors++; $display("FAIL ce_drop_read: got data=%h stall=%b want data=0 stall=0", rom_data, stall_req);
        end
        fetch(1'b1, 32'h4);
        checks++; if (rom_data !== W1 || stall_req !== 1'b0) begin
            errors++; $display("FAIL ce_drop_hit: got data=%h stall=%b want data=%h stall=0", rom_data, stall_req, W1);
        end
    endtask

    task automatic test_addr_change_in_read;
        fetch(1'b1, 32'h0);
        fetch(1'b1, 32'h4);
        checks++; if (rom_data !== W0) begin errors++; $display("FAIL read_orig_data: got %h want %h", rom_data, W0); end
        fetch(1'b1, 32'h4);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL read_orig_tag: got stall=%b want 1", stall_req); end
    endtask

    task automatic test_reset_mid_read;
        // The previous task left a miss pending, so the DUT is now in READ.
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b1 || rom_data !== 32'h0 || ld_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_read: got stall=%b data=%h ready=%b want 1/0/1", stall_req, rom_data, ld_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (stall_req !== 1'b1 || ld_ready !== 1'b1) begin
            errors++; $display("FAIL post_rst_boot: got stall=%b ready=%b want 1/1", stall_req, ld_ready);
        end
        ld_done = 1'b1;
        @(negedge clk);
        ld_done = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL post_rst_miss: got %b want 1", stall_req); end
        fetch(1'b1, 32'h4);
        checks++; if (rom_data !== W1) begin errors++; $display("FAIL post_rst_ram_kept: got %h want %h", rom_data, W1); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_miss_then_hit();
        test_back_to_back();
        test_addr_err();
        test_ld_ignored();
        test_ce_drop();
        test_addr_change_in_read();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
